sccb_arbiter: RTL and testbench

Shares the single SCCB interface (register-write engine) among `NUM_REQ` independent requesters: the power-up config sequencer (requester 0) and runtime tuners such as exposure/white-balance loops. It performs round-robin arbitration, captures the winning address/data pair and issues one start. It tracks the interface's ready drop/rise to detect completion, enforces a programmable inter-write guard gap, and returns a per-requester acknowledge with a timeout error flag.

---
 rtl/ov7670_pkg.sv | 27 ++
 rtl/sccb_rr_picker.sv | 37 +++
 rtl/sccb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sccb_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ov7670_pkg                                         |
// | Description : Shared types and constants for the OV7670 camera   |
// |               control path (SCCB arbiter FSM encoding, widths).  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package ov7670_pkg;

    localparam int SCCB_ADDR_W = 8;
    localparam int SCCB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GUARD     = 2'd3
    } sccb_arb_state_t;

    // Larger of two integers, used when sizing shared counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sccb_rr_picker                                     |
// | Description : Combinational round-robin picker. Searches req     |
// |               starting one above 'last' with wrap-around and     |
// |               returns a one-hot winner plus a valid flag.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sccb_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [IDX_W-1:0] w_idx;

    // First set request after 'last' wins; 'last' itself is checked last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sccb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sccb_arbiter                                       |
// | Description : Round-robin arbiter sharing one SCCB write engine  |
// |               among NUM_REQ requesters. Issues a start, tracks   |
// |               ready drop/rise, enforces a guard gap and returns  |
// |               a per-requester ack with a timeout error flag.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sccb_arbiter
    import ov7670_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int GUARD_CYCLES = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_addr,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       err,
    input  logic                       sccb_ready,
    output logic                       sccb_start,
    output logic [SCCB_ADDR_W-1:0]     sccb_addr,
    output logic [SCCB_DATA_W-1:0]     sccb_data
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Counter must hold BUSY_TIMEOUT-1 and GUARD_CYCLES; keep at least 1 bit.
    localparam int c_cnt_w = max_int(1, $clog2(max_int(BUSY_TIMEOUT, GUARD_CYCLES + 1)));

    localparam logic [c_cnt_w-1:0] c_busy_load  = c_cnt_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_guard_load = c_cnt_w'(GUARD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_last_rst   = c_idx_w'(NUM_REQ - 1);

    sccb_arb_state_t          r_state, w_state;
    logic [NUM_REQ-1:0]       r_grant, w_grant;
    logic [NUM_REQ-1:0]       r_ack,   w_ack;
    logic                     r_err,   w_err;
    logic                     r_start, w_start;
    logic [SCCB_ADDR_W-1:0]   r_addr,  w_addr;
    logic [SCCB_DATA_W-1:0]   r_data,  w_data;
    logic [c_idx_w-1:0]       r_last,  w_last;
    logic [c_cnt_w-1:0]       r_cnt,   w_cnt;

    logic [NUM_REQ-1:0]       w_pick;
    logic                     w_pick_valid;
    logic [c_idx_w-1:0]       w_pick_idx;
    logic [SCCB_ADDR_W-1:0]   w_pick_addr;
    logic [SCCB_DATA_W-1:0]   w_pick_data;

    sccb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_picker (
        .req     (req),
        .last    (r_last),
        .winner  (w_pick),
        .valid   (w_pick_valid)
    );

    // Encode the one-hot winner and select its packed addr/data slices.
    always_comb begin
        w_pick_idx  = '0;
        w_pick_addr = '0;
        w_pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx  = c_idx_w'(i);
                w_pick_addr = req_addr[8*i +: SCCB_ADDR_W];
                w_pick_data = req_data[8*i +: SCCB_DATA_W];
            end
        end
    end

    // Next-state and registered-output logic; pulses default low.
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_ack   = '0;
        w_err   = 1'b0;
        w_start = 1'b0;
        w_addr  = r_addr;
        w_data  = r_data;
        w_last  = r_last;
        w_cnt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid && sccb_ready) begin
                    w_grant = w_pick;
                    w_last  = w_pick_idx;
                    w_addr  = w_pick_addr;
                    w_data  = w_pick_data;
                    w_start = 1'b1;
                    w_cnt   = c_busy_load;
                    w_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!sccb_ready) begin
                    w_state = WAIT_DONE;
                end else if (r_cnt == '0) begin
                    // Engine never went busy: complete with error.
                    w_ack   = r_grant;
                    w_err   = 1'b1;
                    w_grant = '0;
                    w_cnt   = c_guard_load;
                    w_state = GUARD;
                end else begin
                    w_cnt = r_cnt - c_cnt_one;
                end
            end
            WAIT_DONE: begin
                if (sccb_ready) begin
                    w_ack   = r_grant;
                    w_grant = '0;
                    w_cnt   = c_guard_load;
                    w_state = GUARD;
                end
            end
            GUARD: begin
                if (r_cnt == '0) begin
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt - c_cnt_one;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State register: reset wins regardless of clk_en, otherwise advance when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
        end else if (clk_en) begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_start <= w_start;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
        end
    end

    assign grant      = r_grant;
    assign ack        = r_ack;
    assign err        = r_err;
    assign sccb_start = r_start;
    assign sccb_addr  = r_addr;
    assign sccb_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sccb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_sccb_arbiter                                    |
// | Description : Directed self-checking bench for sccb_arbiter with |
// |               a simple SCCB ready model and a start scoreboard.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_sccb_arbiter;

    localparam int NR = 3;
    localparam int GC = 4;
    localparam int BT = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_addr;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   ack;
    logic            err;
    logic            sccb_ready;
    logic            sccb_start;
    logic [7:0]      sccb_addr;
    logic [7:0]      sccb_data;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [7:0]    addr;
        logic [7:0]    data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Model / enable-generator controls
    logic div4     = 1'b0;
    logic model_on = 1'b1;
    int   drop_dly = 3;
    int   busy_len = 40;

    sccb_arbiter #(
        .NUM_REQ      (NR),
        .GUARD_CYCLES (GC),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .grant      (grant),
        .ack        (ack),
        .err        (err),
        .sccb_ready (sccb_ready),
        .sccb_start (sccb_start),
        .sccb_addr  (sccb_addr),
        .sccb_data  (sccb_data)
    );

    always #5 clk = ~clk;

    task automatic raw_step();
        @(posedge clk);
        #1;
    endtask

    // Advance until just after the next edge at which clk_en was high.
    task automatic en_step();
        logic e;
        do begin
            @(negedge clk);
            e = clk_en;
            @(posedge clk);
            #1;
        end while (!e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            en_step();
            n++;
        end while (sccb_start !== 1'b1 && n < 300);
        chk({tag, "_start_seen"}, 32'(sccb_start), 32'd1);
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            en_step();
            n++;
        end while (ack === '0 && n < 300);
        chk({tag, "_ack_seen"}, 32'(ack !== '0), 32'd1);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_grant"}, 32'(grant), 32'(e.grant));
            chk({tag, "_addr"},  32'(sccb_addr), 32'(e.addr));
            chk({tag, "_data"},  32'(sccb_data), 32'(e.data));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_ack"},   32'(ack), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_start"}, 32'(sccb_start), 32'd0);
        chk({tag, "_addr"},  32'(sccb_addr), 32'd0);
        chk({tag, "_data"},  32'(sccb_data), 32'd0);
    endtask

    // Clock-enable generator: always on, or one edge in four.
    initial begin
        int phase;
        phase  = 0;
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (div4) begin
                phase  = (phase + 1) % 4;
                clk_en = (phase == 0);
            end else begin
                phase  = 0;
                clk_en = 1'b1;
            end
        end
    end

    // SCCB engine model: after a start, drop ready then raise it again.
    initial begin
        sccb_ready = 1'b1;
        forever begin
            en_step();
            if (model_on && sccb_start === 1'b1) begin
                repeat (drop_dly) en_step();
                sccb_ready = 1'b0;
                repeat (busy_len) en_step();
                sccb_ready = 1'b1;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   k;
        int   starts;
        int   grants;
        exp_t e;
        time  t_req, t_s, t_a;

        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        repeat (3) raw_step();
        chk_zero("reset");
        rst_n = 1'b1;

        // ---- Single requester, ready drops 3 cycles after start, busy 40
        req_addr[7:0] = 8'h12;
        req_data[7:0] = 8'h80;
        e = '{grant: 3'b001, addr: 8'h12, data: 8'h80};
        sb.push_back(e);
        req = 3'b001;
        wait_start("t1", n);
        chk("t1_req_to_start", n, 1);
        sb_check("t1");
        wait_ack("t1", n);
        chk("t1_start_to_ack", n, drop_dly + busy_len + 1);
        chk("t1_ack", 32'(ack), 32'b001);
        chk("t1_err", 32'(err), 0);
        sb.push_back(e);
        wait_start("t1b", n);
        chk("t1_ack_to_next_start", n, GC + 2);
        sb_check("t1b");
        req = '0;
        wait_ack("t1b", n);
        chk("t1b_ack", 32'(ack), 32'b001);
        en_step();
        chk("t1b_ack_one_cycle", 32'(ack), 0);
        chk("t1b_grant_cleared", 32'(grant), 0);
        repeat (8) en_step();

        // ---- Contention, all three held, fresh pointer
        rst_n = 1'b0;
        raw_step();
        rst_n    = 1'b1;
        busy_len = 5;
        req_addr = {8'h22, 8'h21, 8'h20};
        req_data = {8'hA2, 8'hA1, 8'hA0};
        sb.push_back('{grant: 3'b001, addr: 8'h20, data: 8'hA0});
        sb.push_back('{grant: 3'b010, addr: 8'h21, data: 8'hA1});
        sb.push_back('{grant: 3'b100, addr: 8'h22, data: 8'hA2});
        sb.push_back('{grant: 3'b001, addr: 8'h20, data: 8'hA0});
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            logic [NR-1:0] g;
            wait_start($sformatf("t2_%0d", i), n);
            g = grant;
            sb_check($sformatf("t2_%0d", i));
            if (i == 3) req = '0;
            wait_ack($sformatf("t2_%0d", i), n);
            chk($sformatf("t2_%0d_ack", i), 32'(ack), 32'(g));
            chk($sformatf("t2_%0d_err", i), 32'(err), 0);
        end
        repeat (8) en_step();

        // ---- Timeout with ready stuck high
        model_on      = 1'b0;
        req_addr[7:0] = 8'h33;
        req_data[7:0] = 8'h44;
        e = '{grant: 3'b001, addr: 8'h33, data: 8'h44};
        sb.push_back(e);
        sb.push_back(e);
        req = 3'b001;
        wait_start("t3", n);
        sb_check("t3");
        wait_ack("t3", n);
        chk("t3_start_to_ack", n, BT);
        chk("t3_ack", 32'(ack), 32'b001);
        chk("t3_err", 32'(err), 1);
        wait_start("t3b", n);
        chk("t3_no_start_in_guard", n, GC + 2);
        sb_check("t3b");
        req = '0;
        wait_ack("t3b", n);
        chk("t3b_start_to_ack", n, BT);
        chk("t3b_err", 32'(err), 1);
        repeat (8) en_step();
        model_on = 1'b1;

        // ---- clk_en one edge in four
        div4          = 1'b1;
        req_addr[7:0] = 8'h4C;
        req_data[7:0] = 8'h4D;
        sb.push_back('{grant: 3'b001, addr: 8'h4C, data: 8'h4D});
        t_req = $time;
        req   = 3'b001;
        wait_start("t4", n);
        t_s = $time;
        chk("t4_req_to_start_ns", 32'(t_s - t_req), 40);
        sb_check("t4");
        k = 0;
        do begin
            raw_step();
            k++;
        end while (sccb_start === 1'b1 && k < 20);
        chk("t4_start_width_clks", k, 4);
        wait_ack("t4", n);
        t_a = $time;
        chk("t4_start_to_ack_ns", 32'(t_a - t_s), (drop_dly + busy_len + 1) * 40);
        chk("t4_ack", 32'(ack), 32'b001);
        req  = '0;
        div4 = 1'b0;
        repeat (8) en_step();

        // ---- Reset in WAIT_DONE, then pending req[1] and req[0]
        busy_len      = 40;
        req_addr[7:0] = 8'h55;
        req_data[7:0] = 8'h56;
        sb.push_back('{grant: 3'b001, addr: 8'h55, data: 8'h56});
        req = 3'b001;
        wait_start("t5", n);
        sb_check("t5");
        repeat (10) en_step();
        rst_n          = 1'b0;
        req            = 3'b011;
        req_addr[15:8] = 8'h57;
        req_data[15:8] = 8'h58;
        raw_step();
        chk_zero("t5_midreset");
        raw_step();
        rst_n = 1'b1;
        sb.push_back('{grant: 3'b001, addr: 8'h55, data: 8'h56});
        sb.push_back('{grant: 3'b010, addr: 8'h57, data: 8'h58});
        for (int i = 0; i < 2; i++) begin
            logic [NR-1:0] g;
            wait_start($sformatf("t5_%0d", i), n);
            g = grant;
            sb_check($sformatf("t5_%0d", i));
            wait_ack($sformatf("t5_%0d", i), n);
            chk($sformatf("t5_%0d_ack", i), 32'(ack), 32'(g));
            chk($sformatf("t5_%0d_err", i), 32'(err), 0);
            req = (i == 0) ? 3'b010 : 3'b000;
        end
        repeat (8) en_step();

        // ---- Withdrawn request is never granted
        req_addr[7:0] = 8'h66;
        req_data[7:0] = 8'h67;
        sb.push_back('{grant: 3'b001, addr: 8'h66, data: 8'h67});
        req = 3'b001;
        wait_start("t6", n);
        sb_check("t6");
        repeat (5) en_step();
        req = 3'b011;
        repeat (5) en_step();
        req = 3'b001;
        wait_ack("t6", n);
        chk("t6_ack", 32'(ack), 32'b001);
        req    = '0;
        starts = 0;
        grants = 0;
        for (int i = 0; i < 30; i++) begin
            en_step();
            if (sccb_start === 1'b1) starts++;
            if (grant !== '0) grants++;
        end
        chk("t6_no_start", starts, 0);
        chk("t6_no_grant", grants, 0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
